calc_cmd_sequencer: RTL and testbench
=====================================

CALC_CMD_SEQUENCER -- requirements
Module: calc_cmd_sequencer

Interface
REQ-001 The block SHALL use clock clk, with reset rst asynchronous and active-high.
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_func  in  3  000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 square
- cmd_operand  in  8  unsigned operand
- cmd_first  in  1  load operand into accumulator (no ALU op)
- err_clr  in  1  clears error state
- alu_start  out  1  one-cycle request to datapath
- alu_func  out  3  operation to datapath
- alu_a  out  32  accumulator operand
- alu_b  out  8  command operand
- alu_done  in  1  datapath result valid
- alu_result  in  32  datapath result
- acc  out  32  current accumulator
- busy  out  1  FIFO non-empty or state not IDLE
- err  out  1  sticky error flag
- op_count  out  8  completed ALU operations

Function
REQ-003 The block SHALL buffer commands {first, func, operand} in a 4-entry FIFO.
REQ-004 cmd_ready SHALL equal (FIFO not full) AND (state != ERROR); a push while full SHALL NOT occur, even with a simultaneous pop.
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT and ERROR.
REQ-006 In IDLE with the FIFO non-empty, the block SHALL pop the head in that cycle and apply REQ-007..REQ-009 to it.
REQ-007 A popped command with first=1 SHALL set acc to zero-extended operand on the next edge; the state SHALL remain IDLE and op_count SHALL be unchanged.
REQ-008 A popped command that is div or mod with operand 0, or that has func 110 or 111, SHALL set err=1 and enter ERROR; acc SHALL be unchanged.
REQ-009 Any other popped command SHALL be latched and the FSM SHALL enter ISSUE.
REQ-010 In ISSUE, alu_start SHALL be high for exactly one cycle and the FSM SHALL then enter WAIT.
REQ-011 alu_func, alu_a (acc snapshot) and alu_b SHALL be held stable from ISSUE until the WAIT exit.
REQ-012 alu_done SHALL be sampled only in WAIT; on alu_done, acc SHALL load alu_result, op_count SHALL increment (255 wraps to 0) and the FSM SHALL return to IDLE.
REQ-013 Minimum throughput SHALL be one ALU command per 3 cycles when alu_done returns in the first WAIT cycle.
REQ-014 On entry to ERROR the FIFO SHALL be flushed; commands SHALL be refused while in ERROR.
REQ-015 In ERROR, err_clr SHALL clear err and return the FSM to IDLE; acc and op_count SHALL be kept. err_clr SHALL be ignored in other states.
REQ-016 alu_result SHALL be used unmodified (32-bit, no saturation).

Reset
REQ-017 On rst: state IDLE, FIFO empty, acc=0, op_count=0, err=0, alu_start=0, alu_func=0, alu_a=0, alu_b=0, busy=0; cmd_ready=1 from the first cycle after reset deasserts.
REQ-018 An rst assertion mid-operation SHALL abandon the in-flight command; a later alu_done SHALL be ignored.

Configuration
REQ-019 With CALC_SEQ_TIMEOUT_EN defined, a 4-bit WAIT counter SHALL force err=1 and ERROR after 16 WAIT cycles without alu_done, leaving acc unchanged.
REQ-020 Without CALC_SEQ_TIMEOUT_EN, WAIT SHALL last indefinitely until alu_done arrives.

Verification
REQ-021 Push (first,5), then (add,3), with done 1 cycle after start -> acc=8, op_count=1, exactly one alu_start pulse with alu_a=5, alu_b=3.
REQ-022 Push 5 commands back-to-back with alu_done held low -> cmd_ready=0 after 4 entries are queued; no command is lost or duplicated.
REQ-023 acc=20, push (div,0) -> err=1, FIFO flushed, acc=20; assert err_clr -> err=0, IDLE; then (sub,4) -> acc=16.
REQ-024 acc=0xFFFFFFFF and op_count=255, push (add,1) with the datapath returning 0 -> acc=0, op_count=0.
REQ-025 Assert rst during WAIT, then pulse alu_done -> all outputs stay at reset values.
REQ-026 With CALC_SEQ_TIMEOUT_EN defined, hold alu_done low -> err=1 exactly 16 cycles after entry to WAIT; without the macro, err stays 0.

Source files
------------

// File: rtl/calc_cmd_sequencer.sv
// Accumulator command sequencer: a 4-deep command FIFO feeding an external ALU datapath.
// Optional build macro CALC_SEQ_TIMEOUT_EN aborts a WAIT that sees no alu_done for 16 cycles.
module calc_cmd_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_func,
    input  logic [7:0]  cmd_operand,
    input  logic        cmd_first,
    input  logic        err_clr,
    output logic        alu_start,
    output logic [2:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic [31:0] acc,
    output logic        busy,
    output logic        err,
    output logic [7:0]  op_count
);

    localparam logic [2:0] FuncDiv = 3'd3;
    localparam logic [2:0] FuncMod = 3'd4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERROR} state_e;

    state_e      state_q, state_d;
    logic [11:0] fifoMem_q [4];
    logic [1:0]  wrPtr_q, wrPtr_d;
    logic [1:0]  rdPtr_q, rdPtr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] aluA_q, aluA_d;
    logic [2:0]  aluFunc_q, aluFunc_d;
    logic [7:0]  aluB_q, aluB_d;
    logic [7:0]  opCount_q, opCount_d;
    logic        err_q, err_d;

    logic        fifoFull, fifoEmpty;
    logic        push, pop, flush;
    logic        headFirst;
    logic [2:0]  headFunc;
    logic [7:0]  headOperand;
    logic        headIllegal;

`ifdef CALC_SEQ_TIMEOUT_EN
    logic [3:0]  waitCnt_q, waitCnt_d;
`endif

    assign fifoFull  = (count_q == 3'd4);
    assign fifoEmpty = (count_q == 3'd0);
    assign cmd_ready = !fifoFull && (state_q != ERROR);
    assign push      = cmd_valid && cmd_ready;

    assign {headFirst, headFunc, headOperand} = fifoMem_q[rdPtr_q];
    // Undefined function codes and division by zero are both rejected before reaching the datapath.
    assign headIllegal = (headFunc[2:1] == 2'b11) ||
                         (((headFunc == FuncDiv) || (headFunc == FuncMod)) && (headOperand == 8'd0));

    assign alu_start = (state_q == ISSUE);
    assign alu_func  = aluFunc_q;
    assign alu_a     = aluA_q;
    assign alu_b     = aluB_q;
    assign acc       = acc_q;
    assign err       = err_q;
    assign op_count  = opCount_q;
    assign busy      = !fifoEmpty || (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        aluA_d    = aluA_q;
        aluFunc_d = aluFunc_q;
        aluB_d    = aluB_q;
        opCount_d = opCount_q;
        err_d     = err_q;
        pop       = 1'b0;
        flush     = 1'b0;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
`ifdef CALC_SEQ_TIMEOUT_EN
        waitCnt_d = waitCnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop = 1'b1;
                    if (headFirst) begin
                        acc_d = {24'd0, headOperand};
                    end else if (headIllegal) begin
                        err_d   = 1'b1;
                        flush   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        aluFunc_d = headFunc;
                        aluA_d    = acc_q;
                        aluB_d    = headOperand;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef CALC_SEQ_TIMEOUT_EN
                waitCnt_d = 4'd0;
`endif
            end
            WAIT: begin
                if (alu_done) begin
                    acc_d     = alu_result;
                    opCount_d = opCount_q + 8'd1;
                    state_d   = IDLE;
                end
`ifdef CALC_SEQ_TIMEOUT_EN
                else if (waitCnt_q == 4'd15) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = ERROR;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
`endif
            end
            ERROR: begin
                if (err_clr) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush wins over any push accepted in the same cycle.
        if (flush) begin
            wrPtr_d = 2'd0;
            rdPtr_d = 2'd0;
            count_d = 3'd0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + 2'd1;
            if (pop)  rdPtr_d = rdPtr_q + 2'd1;
            count_d = count_q + {2'd0, push} - {2'd0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wrPtr_q   <= 2'd0;
            rdPtr_q   <= 2'd0;
            count_q   <= 3'd0;
            acc_q     <= 32'd0;
            aluA_q    <= 32'd0;
            aluFunc_q <= 3'd0;
            aluB_q    <= 8'd0;
            opCount_q <= 8'd0;
            err_q     <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
            waitCnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            aluA_q    <= aluA_d;
            aluFunc_q <= aluFunc_d;
            aluB_q    <= aluB_d;
            opCount_q <= opCount_d;
            err_q     <= err_d;
`ifdef CALC_SEQ_TIMEOUT_EN
            waitCnt_q <= waitCnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q] <= {cmd_first, cmd_func, cmd_operand};
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Randomized scoreboard bench for calc_cmd_sequencer with a behavioural datapath and accumulator model.
// Honours CALC_SEQ_TIMEOUT_EN for the WAIT timeout scenario.
module tb_calc_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_func;
    logic [7:0]  cmd_operand;
    logic        cmd_first;
    logic        err_clr;
    logic        alu_start;
    logic [2:0]  alu_func;
    logic [31:0] alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [31:0] acc;
    logic        busy;
    logic        err;
    logic [7:0]  op_count;

    logic        rspDone;
    logic [31:0] rspResult;
    logic        manualDone;

    assign alu_done   = rspDone | manualDone;
    assign alu_result = manualDone ? 32'hDEADBEEF : rspResult;

    calc_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
        .cmd_operand(cmd_operand), .cmd_first(cmd_first), .err_clr(err_clr),
        .alu_start(alu_start), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .acc(acc), .busy(busy), .err(err), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  func;
        logic [31:0] a;
        logic [7:0]  b;
        logic [31:0] accAfter;
        logic [7:0]  opsAfter;
    } exp_t;

    exp_t        expQ[$];
    exp_t        pendExp;
    bit          pendingValid;
    bit          checkNext;
    int          checks;
    int          failures;
    int          startCount;
    int          resetGen;
    bit          respEnable;
    int          maxExtra;
    logic [31:0] refAcc;
    logic [7:0]  refOps;

    function automatic logic [31:0] refAlu(input logic [2:0] f, input logic [31:0] a, input logic [7:0] b);
        logic [31:0] bz;
        bz = {24'd0, b};
        case (f)
            3'd0:    return a + bz;
            3'd1:    return a - bz;
            3'd2:    return a * bz;
            3'd3:    return a / bz;
            3'd4:    return a % bz;
            3'd5:    return a * a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Sequential meaning of one accepted command: first loads, anything else is one ALU transaction.
    task automatic modelCmd(input logic f, input logic [2:0] fn, input logic [7:0] op);
        exp_t e;
        if (f) begin
            refAcc = {24'd0, op};
        end else begin
            e.func = fn;
            e.a    = refAcc;
            e.b    = op;
            refAcc = refAlu(fn, refAcc, op);
            refOps = refOps + 8'd1;
            e.accAfter = refAcc;
            e.opsAfter = refOps;
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic [2:0] fn, input logic [7:0] op, input bit model);
        bit accepted;
        accepted    = 1'b0;
        cmd_valid   = 1'b1;
        cmd_first   = f;
        cmd_func    = fn;
        cmd_operand = op;
        for (int i = 0; i < 400 && !accepted; i++) begin
            if (cmd_ready) accepted = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!accepted) failNote("push_accept");
        else if (model) modelCmd(f, fn, op);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((busy || expQ.size() != 0 || pendingValid || checkNext) && n < 3000);
        if (n >= 3000) failNote("drain");
    endtask

    task automatic waitStart();
        int s;
        int n;
        s = startCount;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (startCount == s && n < 50);
        if (startCount == s) failNote("alu_start_seen");
    endtask

    task automatic doReset();
        rst = 1'b1;
        resetGen++;
        expQ.delete();
        pendingValid = 1'b0;
        checkNext    = 1'b0;
        refAcc       = 32'd0;
        refOps       = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkOutput();
        #1;
        checkVal("rst_acc",       acc,               32'd0);
        checkVal("rst_op_count",  {24'd0, op_count}, 32'd0);
        checkVal("rst_err",       {31'd0, err},      32'd0);
        checkVal("rst_busy",      {31'd0, busy},     32'd0);
        checkVal("rst_alu_start", {31'd0, alu_start}, 32'd0);
        checkVal("rst_alu_func",  {29'd0, alu_func}, 32'd0);
        checkVal("rst_alu_a",     alu_a,             32'd0);
        checkVal("rst_alu_b",     {24'd0, alu_b},    32'd0);
        checkVal("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Monitor: pops an expectation on every alu_start and checks acc/op_count after the matching alu_done.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (checkNext) begin
                    checkVal("sb_acc",      acc,               pendExp.accAfter);
                    checkVal("sb_op_count", {24'd0, op_count}, {24'd0, pendExp.opsAfter});
                    checkNext    = 1'b0;
                    pendingValid = 1'b0;
                end
                if (alu_start) begin
                    startCount++;
                    if (expQ.size() == 0) begin
                        failNote("sb_unexpected_start");
                    end else begin
                        pendExp = expQ.pop_front();
                        checkVal("sb_alu_func", {29'd0, alu_func}, {29'd0, pendExp.func});
                        checkVal("sb_alu_a",    alu_a,             pendExp.a);
                        checkVal("sb_alu_b",    {24'd0, alu_b},    {24'd0, pendExp.b});
                        pendingValid = 1'b1;
                    end
                end
                if (alu_done && pendingValid) checkNext = 1'b1;
            end
        end
    end

    // Datapath stand-in: answers each alu_start after a random number of WAIT cycles.
    initial begin : responder
        int          myGen;
        logic [31:0] res;
        rspDone   = 1'b0;
        rspResult = 32'd0;
        forever begin
            @(negedge clk);
            if (alu_start && !rst) begin
                myGen = resetGen;
                res   = refAlu(alu_func, alu_a, alu_b);
                @(posedge clk); #1;
                if (!respEnable) begin
                    wait (respEnable || myGen != resetGen);
                    @(posedge clk); #1;
                end
                if (myGen == resetGen) begin
                    repeat ($urandom_range(0, maxExtra)) begin
                        @(posedge clk); #1;
                    end
                    rspDone   = 1'b1;
                    rspResult = res;
                    @(posedge clk); #1;
                    rspDone = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [2:0] fn;
        logic [7:0] op;
        int         guard;
        int         n;

        checks = 0; failures = 0; startCount = 0; resetGen = 0;
        pendingValid = 1'b0; checkNext = 1'b0;
        respEnable = 1'b1; maxExtra = 0; manualDone = 1'b0;
        cmd_valid = 1'b0; cmd_first = 1'b0; cmd_func = 3'd0; cmd_operand = 8'd0; err_clr = 1'b0;
        refAcc = 32'd0; refOps = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput();

        // First-load then add with the result returned in the first WAIT cycle.
        applyStimulus(1'b1, 3'd0, 8'd5, 1'b1);
        applyStimulus(1'b0, 3'd0, 8'd3, 1'b1);
        waitIdle();
        checkVal("basic_acc",      acc,               32'd8);
        checkVal("basic_op_count", {24'd0, op_count}, 32'd1);

        // Five back-to-back commands with the datapath stalled fill the FIFO.
        respEnable = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 3'(i), 8'(i + 2), 1'b1);
        checkVal("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkVal("full_busy",      {31'd0, busy},      32'd1);
        respEnable = 1'b1;
        waitIdle();

        // Division by zero behind a stalled multiply; the command queued after it must be flushed.
        applyStimulus(1'b1, 3'd0, 8'd20, 1'b1);
        respEnable = 1'b0;
        applyStimulus(1'b0, 3'd2, 8'd1, 1'b1);
        applyStimulus(1'b0, 3'd3, 8'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'd7, 1'b0);
        respEnable = 1'b1;
        n = 0;
        while (!err && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        checkVal("err_set",       {31'd0, err},       32'd1);
        checkVal("err_acc",       acc,                32'd20);
        checkVal("err_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (4) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        checkVal("clr_err",       {31'd0, err},       32'd0);
        checkVal("clr_busy",      {31'd0, busy},      32'd0);
        checkVal("clr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        applyStimulus(1'b0, 3'd1, 8'd4, 1'b1);
        waitIdle();
        checkVal("clr_sub_acc", acc, 32'd16);

        // Random traffic until the operation counter is one step from wrapping.
        maxExtra = 3;
        guard = 0;
        while (refOps != 8'd254 && guard < 2000) begin
            guard++;
            if ($urandom_range(0, 4) == 0) begin
                applyStimulus(1'b1, 3'd0, 8'($urandom), 1'b1);
            end else begin
                fn = 3'($urandom_range(0, 5));
                op = 8'($urandom);
                if ((fn == 3'd3 || fn == 3'd4) && op == 8'd0) op = 8'd1;
                applyStimulus(1'b0, fn, op, 1'b1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        applyStimulus(1'b1, 3'd0, 8'd0, 1'b1);
        applyStimulus(1'b0, 3'd1, 8'd1, 1'b1);
        waitIdle();
        checkVal("wrap_pre_acc",      acc,               32'hFFFFFFFF);
        checkVal("wrap_pre_op_count", {24'd0, op_count}, 32'd255);
        applyStimulus(1'b0, 3'd0, 8'd1, 1'b1);
        waitIdle();
        checkVal("wrap_acc",      acc,               32'd0);
        checkVal("wrap_op_count", {24'd0, op_count}, 32'd0);
        checkVal("sb_queue_empty", expQ.size(), 32'd0);

        // Reset in WAIT, then a stray alu_done must not disturb the reset state.
        respEnable = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'd5, 1'b1);
        waitStart();
        @(negedge clk);
        doReset();
        @(posedge clk); #1;
        manualDone = 1'b1;
        @(posedge clk); #1;
        manualDone = 1'b0;
        @(negedge clk);
        checkOutput();
        respEnable = 1'b1;

        // A datapath that never answers: timeout only in the macro build.
        respEnable = 1'b0;
        applyStimulus(1'b0, 3'd0, 8'd2, 1'b1);
        waitStart();
        repeat (16) @(negedge clk);
        checkVal("timeout_err_early", {31'd0, err}, 32'd0);
        @(negedge clk);
`ifdef CALC_SEQ_TIMEOUT_EN
        checkVal("timeout_err", {31'd0, err}, 32'd1);
        checkVal("timeout_acc", acc,          32'd0);
        doReset();
        respEnable = 1'b1;
`else
        checkVal("no_timeout_err", {31'd0, err}, 32'd0);
        repeat (24) @(negedge clk);
        checkVal("no_timeout_err_late", {31'd0, err}, 32'd0);
        respEnable = 1'b1;
        waitIdle();
        checkVal("late_done_acc", acc, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
